// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types: stage-register state encoding and per-boundary ctrl structs
// with their bubble constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_ONE,
        PS_TWO
    } pipe_state_t;

    typedef struct packed {
        logic       reg_wr;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic       mem_to_reg;
        logic [3:0] alu_op;
        logic [4:0] wsel;
        logic [6:0] rsvd;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '0;

    typedef struct packed {
        logic       reg_wr;
        logic       dren;
        logic       dwen;
        logic       halt;
        logic [4:0] wsel;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with flush-to-bubble.
// PIPE_STAGE_SKID_EN adds a skid entry so up_ready becomes a pure function of state.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = 24,
    parameter int unsigned       DATA_W      = 96,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    pipe_state_t       state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              up_fire, dn_fire;

`ifdef PIPE_STAGE_SKID_EN
    assign up_ready = (state_q != PS_TWO) & ~RST;
`else
    assign up_ready = ((state_q == PS_EMPTY) | dn_ready) & ~RST;
`endif

    // Gated by RST so outputs are quiet even before the first reset edge.
    assign dn_valid = (state_q != PS_EMPTY) & ~RST;
    assign dn_ctrl  = head_ctrl_q;
    assign dn_data  = head_data_q;
    assign up_fire  = up_valid & up_ready;
    assign dn_fire  = dn_valid & dn_ready;

    always_comb begin
        occupancy = 2'd0;
        if (!RST) begin
            unique case (state_q)
                PS_ONE:  occupancy = 2'd1;
                PS_TWO:  occupancy = 2'd2;
                default: occupancy = 2'd0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Data fields deliberately hold; only ctrl is bubbled.
            state_d     = PS_EMPTY;
            head_ctrl_d = BUBBLE_CTRL;
            skid_ctrl_d = BUBBLE_CTRL;
        end else begin
            unique case (state_q)
                PS_EMPTY: begin
                    if (up_fire) begin
                        head_ctrl_d = up_ctrl;
                        head_data_d = up_data;
                        state_d     = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (up_fire && dn_fire) begin
                        head_ctrl_d = up_ctrl;
                        head_data_d = up_data;
                    end else if (dn_fire) begin
                        state_d = PS_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (up_fire) begin
                        skid_ctrl_d = up_ctrl;
                        skid_data_d = up_data;
                        state_d     = PS_TWO;
`endif
                    end
                end
                PS_TWO: begin
                    if (dn_fire) begin
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        state_d     = PS_ONE;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PS_EMPTY;
            head_ctrl_q <= BUBBLE_CTRL;
            head_data_q <= '0;
            skid_ctrl_q <= BUBBLE_CTRL;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int unsigned CW  = 8;
    localparam int unsigned DW  = 16;
    localparam logic [CW-1:0] BUB = 8'hA5;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, up_valid, dn_ready, flush;
    logic [CW-1:0] up_ctrl;
    logic [DW-1:0] up_data;
    logic          up_ready, dn_valid;
    logic [CW-1:0] dn_ctrl;
    logic [DW-1:0] dn_data;
    logic [1:0]    occupancy;

    int tests = 0;
    int fails = 0;

    // Reference: list of stored beats plus the last visible head contents.
    logic [CW+DW-1:0] mq[$];
    logic [CW-1:0]    m_hctrl;
    logic [DW-1:0]    m_hdata;
    bit               m_known = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W      (CW),
        .DATA_W      (DW),
        .BUBBLE_CTRL (BUB)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_ctrl   (up_ctrl),
        .up_data   (up_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_ctrl   (dn_ctrl),
        .dn_data   (dn_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    task automatic step(input bit uv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit dr, input bit fl, input bit rs);
        bit            e_rdy, e_vld, ufire, dfire;
        logic [1:0]    e_occ;
        up_valid = uv;
        up_ctrl  = c;
        up_data  = d;
        dn_ready = dr;
        flush    = fl;
        rst      = rs;
        @(negedge clk);
        e_vld = !rs && (mq.size() > 0);
        e_occ = rs ? 2'd0 : 2'(mq.size());
        if (CAP == 2) e_rdy = !rs && (mq.size() < 2);
        else          e_rdy = !rs && (mq.size() == 0 || dr);
        tests++;
        assert (up_ready === e_rdy) else begin
            fails++;
            $error("FAIL up_ready: got %b expected %b", up_ready, e_rdy);
        end
        tests++;
        assert (dn_valid === e_vld) else begin
            fails++;
            $error("FAIL dn_valid: got %b expected %b", dn_valid, e_vld);
        end
        tests++;
        assert (occupancy === e_occ) else begin
            fails++;
            $error("FAIL occupancy: got %0d expected %0d", occupancy, e_occ);
        end
        if (m_known) begin
            tests++;
            assert (dn_ctrl === m_hctrl) else begin
                fails++;
                $error("FAIL dn_ctrl: got %h expected %h", dn_ctrl, m_hctrl);
            end
            tests++;
            assert (dn_data === m_hdata) else begin
                fails++;
                $error("FAIL dn_data: got %h expected %h", dn_data, m_hdata);
            end
        end
        ufire = uv && e_rdy;
        dfire = e_vld && dr;
        if (rs) begin
            mq.delete();
            m_hctrl = BUB;
            m_hdata = '0;
            m_known = 1'b1;
        end else if (fl) begin
            mq.delete();
            m_hctrl = BUB;
        end else begin
            if (dfire) void'(mq.pop_front());
            if (ufire) mq.push_back({c, d});
            if (mq.size() > 0) {m_hctrl, m_hdata} = mq[0];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then stream 1,2,3
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(1, 8'd1, 16'h1001, 1, 0, 0);
        step(1, 8'd2, 16'h1002, 1, 0, 0);
        step(1, 8'd3, 16'h1003, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Stall absorb: A on dn, then hold dn_ready low
        step(1, 8'h0A, 16'hAAAA, 1, 0, 0);
        step(1, 8'h0B, 16'hBBBB, 0, 0, 0);
        step(1, 8'h0C, 16'hCCCC, 0, 0, 0);
        step(1, 8'h0C, 16'hCCCC, 0, 0, 0);
        step(1, 8'h0C, 16'hCCCC, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Flush mid-stall with C offered, then D
        step(1, 8'h1A, 16'h1AAA, 0, 0, 0);
        step(1, 8'h1B, 16'h1BBB, 0, 0, 0);
        step(1, 8'h1C, 16'h1CCC, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 8'h1D, 16'h1DDD, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Flush and reset together: data must clear
        step(1, 8'h2A, 16'h2AAA, 0, 0, 0);
        step(1, 8'h2B, 16'h2BBB, 0, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        // Simultaneous fire for 8 beats
        for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 16'(16'h3000 + i), 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Single-cycle dn_ready drop during a stream
        step(1, 8'h41, 16'h4001, 1, 0, 0);
        step(1, 8'h42, 16'h4002, 0, 0, 0);
        step(1, 8'h43, 16'h4003, 1, 0, 0);
        step(1, 8'h44, 16'h4004, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), 16'($urandom), ($urandom % 10) < 7,
                 ($urandom % 32) == 0, ($urandom % 100) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
